// File: rtl/serial_receiver.sv
// Asynchronous serial (UART-style) receiver: 2-flop rx synchronizer, start-bit
// glitch rejection, configurable data width, parity mode and stop-bit count.
module serial_receiver #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int PARITY    = 0,  // 0 none, 1 odd, 2 even, 3 mark, 4 space
  parameter int NUM_BITS  = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [NUM_BITS-1:0] data,
  output logic                valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES) + 1;

  localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);
  localparam logic [3:0]    C_DATA_LAST = 4'(NUM_BITS - 1);
  localparam logic [3:0]    C_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_bit_cnt;
  logic [NUM_BITS-1:0] r_shift;
  logic                r_par;
  logic                r_perr_pend;
  logic                r_ferr_pend;

  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;

  logic w_fall;
  logic w_tick;
  logic w_par_bit_err;

  // Synchronizer flops come out of reset high so an idle line never looks
  // like a falling edge.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;
  assign w_tick = (r_cnt == C_BIT_LAST);

  // NOTE: assign a default before the case so no path leaves the output
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_par_bit_err = 1'b0;
    case (PARITY)
      1:       w_par_bit_err = ~(r_par ^ r_rx_sync);
      2:       w_par_bit_err = r_par ^ r_rx_sync;
      3:       w_par_bit_err = ~r_rx_sync;
      4:       w_par_bit_err = r_rx_sync;
      default: w_par_bit_err = 1'b0;
    endcase
  end

  // NOTE: the shift register and output word are reset too, so data reads 0
  // after reset rather than a stale or unknown word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_cnt <= '0;
          if (w_fall) begin
            r_state     <= S_START;
            busy        <= 1'b1;
            r_par       <= 1'b0;
            r_perr_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
          end
        end

        S_START: begin
          if (r_cnt == C_HALF_LAST) begin
            r_cnt <= '0;
            if (!r_rx_sync) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;  // line went back high: glitch, not a start bit
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= (r_shift >> 1) | (NUM_BITS'(r_rx_sync) << (NUM_BITS - 1));
            r_par   <= r_par ^ r_rx_sync;
            if (r_bit_cnt == C_DATA_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_tick) begin
            r_cnt       <= '0;
            r_perr_pend <= w_par_bit_err;
            r_state     <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_bit_cnt == C_STOP_LAST) begin
              r_bit_cnt  <= '0;
              r_state    <= S_IDLE;
              busy       <= 1'b0;
              valid      <= 1'b1;
              data       <= r_shift;
              parity_err <= r_perr_pend;
              frame_err  <= r_ferr_pend | ~r_rx_sync;
            end else begin
              r_bit_cnt   <= r_bit_cnt + 1'b1;
              r_ferr_pend <= r_ferr_pend | ~r_rx_sync;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
